// File: rtl/y_window_ctrl_if.sv
// Pixel-side handshake and window-control bundle for y_window_ctrl.
// master: pixel source (drives in_valid/in_sof, observes everything else).
// slave : the controller (drives ready, line-buffer writes and window controls).
interface y_window_ctrl_if #(
  parameter int COLW = 10,
  parameter int ROWW = 9
);
  logic            in_valid;
  logic            in_sof;
  logic            in_ready;
  logic [4:0]      wr_en;
  logic [COLW-1:0] wr_addr;
  logic [COLW-1:0] rd_addr;
  logic [2:0]      hsel;
  logic            win_validin;
  logic [ROWW-1:0] out_row;
  logic            frame_done;
  logic            overrun;

  modport master (
    output in_valid, in_sof,
    input  in_ready, wr_en, wr_addr, rd_addr, hsel, win_validin, out_row,
           frame_done, overrun
  );

  modport slave (
    input  in_valid, in_sof,
    output in_ready, wr_en, wr_addr, rd_addr, hsel, win_validin, out_row,
           frame_done, overrun
  );
endinterface

// File: rtl/y_window_ctrl.sv
// Purpose: counts raster columns/rows, steers pixel writes into a ring of five line
//   buffers and drives y_window hsel/validin/out_row, flushing the window at end of frame.
// Latency: writes combinational with the accepted pixel; window controls lag by 1 cycle.
// Backpressure: in_ready constant 1 by default (FLUSH pixels dropped, flagged on overrun);
//   with Y_WINDOW_CTRL_READY_EN defined, in_ready drops in FLUSH except for in_sof.
module y_window_ctrl #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int COLW   = $clog2(WIDTH),
  parameter int ROWW   = $clog2(HEIGHT)
) (
  input logic            clock,
  input logic            reset,
  y_window_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH
  } state_t;

  localparam logic [COLW-1:0] COL_LAST   = COLW'(WIDTH - 1);
  localparam logic [ROWW-1:0] ROW_LAST   = ROWW'(HEIGHT - 1);
  // Rows 0..3 must be buffered before the first 5-row window exists.
  localparam logic [ROWW-1:0] ROW_FILLED = ROWW'(3);
  // Window centre sits two rows behind the row being written.
  localparam logic [ROWW-1:0] ROW_LAG    = ROWW'(2);
  localparam logic [2:0]      SEL_LAST   = 3'd4;
  // Depth of the y_window pipeline that has to be drained.
  localparam logic [2:0]      FLUSH_LEN  = 3'd5;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [COLW-1:0] r_col;
  logic [COLW-1:0] w_col_nxt;
  logic [ROWW-1:0] r_row;
  logic [ROWW-1:0] w_row_nxt;
  logic [2:0]      r_wr_sel;
  logic [2:0]      w_wr_sel_nxt;
  logic [2:0]      r_fcnt;
  logic [2:0]      w_fcnt_nxt;
  logic [2:0]      r_hsel;
  logic [2:0]      w_hsel_nxt;
  logic            r_validin;
  logic            w_validin_nxt;
  logic [ROWW-1:0] r_out_row;
  logic [ROWW-1:0] w_out_row_nxt;
  logic            r_done;
  logic            w_done_nxt;
  logic            r_overrun;
  logic            w_overrun_nxt;

  logic            w_ready;
  logic            w_acc;
  logic            w_sof_acc;
  logic            w_pix_acc;
  logic            w_col_last;
  logic            w_row_last;
  logic [2:0]      w_sel_inc;
  logic [ROWW-1:0] w_row_inc;
  logic [4:0]      w_wr_en;
  logic [COLW-1:0] w_wr_addr;

`ifdef Y_WINDOW_CTRL_READY_EN
  // A new frame may always start, so in_sof overrides the FLUSH back-pressure.
  assign w_ready = (r_state != S_FLUSH) | bus.in_sof;
`else
  assign w_ready = 1'b1;
`endif

  // Reset gates acceptance so no write strobe escapes while reset is held.
  assign w_acc      = bus.in_valid & w_ready & reset;
  assign w_sof_acc  = w_acc & bus.in_sof;
  assign w_pix_acc  = w_acc & ~bus.in_sof & ((r_state == S_FILL) | (r_state == S_RUN));
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);
  assign w_sel_inc  = (r_wr_sel == SEL_LAST) ? 3'd0 : r_wr_sel + 3'd1;
  assign w_row_inc  = w_row_last ? '0 : r_row + ROWW'(1);

  // Write path: one-hot buffer select and column address for the pixel on the bus now.
  always_comb begin
    w_wr_en   = 5'b00000;
    w_wr_addr = r_col;
    if (w_sof_acc) begin
      w_wr_en   = 5'b00001;
      w_wr_addr = '0;
    end else if (w_pix_acc) begin
      w_wr_en = 5'b00001 << r_wr_sel;
    end
  end

  // Next-state, counters and the registered window controls.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_row_nxt     = r_row;
    w_wr_sel_nxt  = r_wr_sel;
    w_fcnt_nxt    = r_fcnt;
    w_hsel_nxt    = r_hsel;
    w_out_row_nxt = r_out_row;
    w_validin_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    w_overrun_nxt = r_overrun;
    if (w_sof_acc) begin
      // The SOF pixel itself is (row 0, col 0) of buffer 0; the next one lands at col 1.
      w_state_nxt   = S_FILL;
      w_col_nxt     = COLW'(1);
      w_row_nxt     = '0;
      w_wr_sel_nxt  = '0;
      w_fcnt_nxt    = '0;
      w_overrun_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Pixels outside a frame are silently discarded.
        end
        S_FILL, S_RUN: begin
          if (w_pix_acc) begin
            if (w_col_last) begin
              w_col_nxt    = '0;
              w_row_nxt    = w_row_inc;
              w_wr_sel_nxt = w_sel_inc;
            end else begin
              w_col_nxt = r_col + COLW'(1);
            end
            if (r_state == S_RUN) begin
              // Rotation one past the write buffer puts h2 on the buffer holding row L-2.
              w_validin_nxt = 1'b1;
              w_hsel_nxt    = w_sel_inc;
              w_out_row_nxt = r_row - ROW_LAG;
            end
            if ((r_state == S_FILL) && w_col_last && (r_row == ROW_FILLED)) begin
              w_state_nxt = S_RUN;
            end
            if ((r_state == S_RUN) && w_col_last && w_row_last) begin
              w_state_nxt = S_FLUSH;
              w_fcnt_nxt  = '0;
            end
          end
        end
        S_FLUSH: begin
          // hsel/out_row hold their last values while the pipeline drains.
          if (r_fcnt != FLUSH_LEN) begin
            w_validin_nxt = 1'b1;
            w_fcnt_nxt    = r_fcnt + 3'd1;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
`ifndef Y_WINDOW_CTRL_READY_EN
          // in_sof was handled above, so any valid here is a dropped pixel.
          if (bus.in_valid) begin
            w_overrun_nxt = 1'b1;
          end
`endif
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // State and output registers; everything returns to idle values on reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_col     <= '0;
      r_row     <= '0;
      r_wr_sel  <= '0;
      r_fcnt    <= '0;
      r_hsel    <= 3'd1;
      r_validin <= 1'b0;
      r_out_row <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_col     <= w_col_nxt;
      r_row     <= w_row_nxt;
      r_wr_sel  <= w_wr_sel_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_hsel    <= w_hsel_nxt;
      r_validin <= w_validin_nxt;
      r_out_row <= w_out_row_nxt;
      r_done    <= w_done_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign bus.in_ready    = w_ready;
  assign bus.wr_en       = w_wr_en;
  assign bus.wr_addr     = w_wr_addr;
  assign bus.rd_addr     = w_wr_addr;
  assign bus.hsel        = r_hsel;
  assign bus.win_validin = r_validin;
  assign bus.out_row     = r_out_row;
  assign bus.frame_done  = r_done;
  assign bus.overrun     = r_overrun;

`ifndef SYNTHESIS
  // Internal invariants: ring indices stay in range and writes are never multi-hot.
  a_wr_en_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(w_wr_en));
  a_sel_range:    assert property (@(posedge clock) disable iff (!reset) r_wr_sel <= SEL_LAST);
  a_hsel_range:   assert property (@(posedge clock) disable iff (!reset) r_hsel <= SEL_LAST);
  a_fcnt_range:   assert property (@(posedge clock) disable iff (!reset) r_fcnt <= FLUSH_LEN);
  a_done_quiet:   assert property (@(posedge clock) disable iff (!reset) r_done |-> !r_validin);
`endif

endmodule

// File: tb/tb_y_window_ctrl.sv
// Bench for y_window_ctrl at WIDTH=8, HEIGHT=6: table-driven frame plus hand sequences
// for gaps, mid-frame restart, FLUSH collisions and asynchronous reset.
module tb_y_window_ctrl;
  localparam int WIDTH  = 8;
  localparam int HEIGHT = 6;
  localparam int COLW   = 3;
  localparam int ROWW   = 3;
`ifdef Y_WINDOW_CTRL_READY_EN
  localparam bit READY_EN = 1'b1;
`else
  localparam bit READY_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   pulses_seen = 0;

  y_window_ctrl_if #(.COLW(COLW), .ROWW(ROWW)) bus ();

  y_window_ctrl #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       v;
    logic       sof;
    logic [4:0] en;
    logic [2:0] addr;
    logic       rdy;
    logic       vld;
    logic [2:0] hsel;
    logic [2:0] orow;
    logic       done;
  } vec_t;

  vec_t tbl [56];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs just after a rising edge, then sit at the falling edge for sampling.
  task automatic step(input logic v, input logic sof);
    @(posedge clock);
    #1;
    bus.in_valid = v;
    bus.in_sof   = sof;
    @(negedge clock);
  endtask

  function automatic logic [4:0] exp_en(input int p);
    logic [4:0] one;
    one = 5'b00001;
    return one << ((p / WIDTH) % 5);
  endfunction

  task automatic pix(input int p, input logic sof);
    step(1'b1, sof);
    chk("wr_en", 32'(bus.wr_en), 32'(exp_en(p)));
    chk("wr_addr", 32'(bus.wr_addr), 32'(p % WIDTH));
    chk("rd_addr", 32'(bus.rd_addr), 32'(p % WIDTH));
    chk("frame_done_in_frame", 32'(bus.frame_done), 0);
  endtask

  // prev_row: row of the pixel accepted last cycle, -1 for a gap.
  task automatic chk_win(input int prev_row);
    if (bus.win_validin === 1'b1) pulses_seen++;
    if (prev_row >= 4) begin
      chk("win_validin", 32'(bus.win_validin), 1);
      chk("hsel", 32'(bus.hsel), (prev_row == 4) ? 0 : 1);
      chk("out_row", 32'(bus.out_row), (prev_row == 4) ? 2 : 3);
    end else begin
      chk("win_validin_idle", 32'(bus.win_validin), 0);
    end
  endtask

  task automatic flush(input int inject_at, output int pulses, output bit done);
    pulses = 0;
    done   = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      if (i == inject_at) begin
        step(1'b1, 1'b0);
        chk("flush_in_ready", 32'(bus.in_ready), READY_EN ? 0 : 1);
        chk("flush_wr_en", 32'(bus.wr_en), 0);
      end else begin
        step(1'b0, 1'b0);
      end
      if (bus.frame_done === 1'b1) done = 1'b1;
      else if (bus.win_validin === 1'b1) pulses++;
    end
  endtask

  task automatic run_frame();
    for (int p = 0; p < WIDTH * HEIGHT; p++) pix(p, p == 0);
    step(1'b0, 1'b0);
    chk_win(5);
  endtask

  initial begin
    int fp;
    bit dn;
    int prev;
    int run_acc;
    int ng;

    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;

    // Table: one continuous frame followed by the flush and frame_done.
    for (int k = 0; k < 56; k++) begin
      tbl[k].v    = (k < 48);
      tbl[k].sof  = (k == 0);
      tbl[k].en   = (k < 48) ? exp_en(k) : 5'b00000;
      tbl[k].addr = (k < 48) ? 3'(k % WIDTH) : 3'd0;
      tbl[k].rdy  = !(READY_EN && k >= 48 && k <= 53);
      tbl[k].vld  = (k >= 33 && k <= 53);
      tbl[k].hsel = (k >= 33 && k <= 40) ? 3'd0 : 3'd1;
      tbl[k].orow = (k >= 33 && k <= 40) ? 3'd2 : 3'd3;
      tbl[k].done = (k == 54);
    end

    // Reset state.
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_addr", 32'(bus.wr_addr), 0);
    chk("rst_rd_addr", 32'(bus.rd_addr), 0);
    chk("rst_hsel", 32'(bus.hsel), 1);
    chk("rst_validin", 32'(bus.win_validin), 0);
    chk("rst_out_row", 32'(bus.out_row), 0);
    chk("rst_frame_done", 32'(bus.frame_done), 0);
    chk("rst_overrun", 32'(bus.overrun), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 56; k++) begin
      step(tbl[k].v, tbl[k].sof);
      chk($sformatf("tbl%0d_wr_en", k), 32'(bus.wr_en), 32'(tbl[k].en));
      chk($sformatf("tbl%0d_wr_addr", k), 32'(bus.wr_addr), 32'(tbl[k].addr));
      chk($sformatf("tbl%0d_in_ready", k), 32'(bus.in_ready), 32'(tbl[k].rdy));
      chk($sformatf("tbl%0d_validin", k), 32'(bus.win_validin), 32'(tbl[k].vld));
      chk($sformatf("tbl%0d_frame_done", k), 32'(bus.frame_done), 32'(tbl[k].done));
      if (tbl[k].vld) begin
        chk($sformatf("tbl%0d_hsel", k), 32'(bus.hsel), 32'(tbl[k].hsel));
        chk($sformatf("tbl%0d_out_row", k), 32'(bus.out_row), 32'(tbl[k].orow));
      end
    end

    // IDLE pixels without in_sof are discarded.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      chk("idle_wr_en", 32'(bus.wr_en), 0);
      chk("idle_validin", 32'(bus.win_validin), 0);
    end

    // Random in_valid gaps while in RUN.
    prev = -1;
    run_acc = 0;
    pulses_seen = 0;
    for (int p = 0; p < WIDTH * HEIGHT; p++) begin
      if (p >= 32) begin
        ng = (p == 33) ? 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          step(1'b0, 1'b0);
          chk_win(prev);
          prev = -1;
        end
      end
      pix(p, p == 0);
      chk_win(prev);
      if (p >= 32) run_acc++;
      prev = p / WIDTH;
    end
    step(1'b0, 1'b0);
    chk_win(prev);
    chk("gap_run_pulses", 32'(pulses_seen), 32'(run_acc));
    flush(-1, fp, dn);
    chk("gap_flush_pulses", 32'(fp), 5);
    chk("gap_frame_done", 32'(dn), 1);

    // Restart at row 3, col 4; the abandoned frame yields no frame_done.
    for (int p = 0; p < 28; p++) pix(p, p == 0);
    pix(0, 1'b1);
    for (int p = 1; p < WIDTH * HEIGHT; p++) pix(p, 1'b0);
    step(1'b0, 1'b0);
    chk_win(5);
    flush(-1, fp, dn);
    chk("restart_flush_pulses", 32'(fp), 5);
    chk("restart_frame_done", 32'(dn), 1);

    // Pixel arriving during FLUSH.
    run_frame();
    flush(1, fp, dn);
    chk("ovr_flush_pulses", 32'(fp), 5);
    chk("ovr_frame_done", 32'(dn), 1);
    step(1'b0, 1'b0);
    chk("ovr_sticky", 32'(bus.overrun), READY_EN ? 0 : 1);

    // in_sof during FLUSH wins; then reset mid-RUN.
    pix(0, 1'b1);
    pix(1, 1'b0);
    chk("ovr_cleared_by_sof", 32'(bus.overrun), 0);
    for (int p = 2; p < WIDTH * HEIGHT; p++) pix(p, 1'b0);
    step(1'b0, 1'b0);
    chk_win(5);
    step(1'b0, 1'b0);
    chk("flush1_validin", 32'(bus.win_validin), 1);
    step(1'b0, 1'b0);
    chk("flush2_validin", 32'(bus.win_validin), 1);
    pix(0, 1'b1);
    chk("flush_sof_ready", 32'(bus.in_ready), 1);
    pix(1, 1'b0);
    chk("flush_sof_validin_drop", 32'(bus.win_validin), 0);
    for (int p = 2; p < 36; p++) pix(p, 1'b0);
    chk_win(4);
    reset = 1'b0;
    #1;
    chk("arst_validin", 32'(bus.win_validin), 0);
    chk("arst_hsel", 32'(bus.hsel), 1);
    chk("arst_wr_en", 32'(bus.wr_en), 0);
    chk("arst_out_row", 32'(bus.out_row), 0);
    chk("arst_overrun", 32'(bus.overrun), 0);
    chk("arst_in_ready", 32'(bus.in_ready), 1);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      chk("post_rst_wr_en", 32'(bus.wr_en), 0);
      chk("post_rst_validin", 32'(bus.win_validin), 0);
    end
    step(1'b0, 1'b0);
    chk("post_rst_validin_end", 32'(bus.win_validin), 0);
    chk("post_rst_frame_done", 32'(bus.frame_done), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
